exc_irq_controller: RTL

EXC_IRQ_CONTROLLER -- requirements
Module: exc_irq_controller

---
 rtl/exc_irq_controller.sv | 104 ++++++++++
 1 files changed

// File: rtl/exc_irq_controller.sv
// Exception/interrupt controller: takes an undefined-instruction exception or an
// external interrupt into a single handler context. Define IRQ_SYNC_EN to synchronize irq.
module exc_irq_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        irq,
  input  logic        exc,
  input  logic [31:0] pc_id,
  input  logic        stall,
  input  logic        redirect,
  input  logic        eret,
  output logic        Interrupt,
  output logic        Exception,
  output logic [31:0] epc,
  output logic        busy,
  output logic        exc_lost
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, PEND, HANDLER} state_t;

  state_t      state, state_nxt;
  logic        pending, pending_nxt;
  logic        irq_eff;
  logic        in_handler;
  logic        user_pc;
  logic        take_exc, take_irq;

  // Exceptions resume after the faulting instruction; the add wraps at 2^32.
  function automatic logic [DATA_W-1:0] next_pc(input logic [DATA_W-1:0] pc);
    return pc + DATA_W'(4);
  endfunction

`ifdef IRQ_SYNC_EN
  logic irq_sync_p0, irq_sync_p1;

  // irq synchronizer stage boundary
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_sync_p0 <= 1'b0;
      irq_sync_p1 <= 1'b0;
    end else begin
      irq_sync_p0 <= irq;
      irq_sync_p1 <= irq_sync_p0;
    end
  end

  assign irq_eff = irq_sync_p1;
`else
  assign irq_eff = irq;
`endif

  assign in_handler = (state == HANDLER);
  assign user_pc    = ~pc_id[31];

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    take_exc    = exc && user_pc && !in_handler;
    take_irq    = (pending || irq_eff) && user_pc && !in_handler &&
                  !stall && !redirect && !take_exc;

    if (take_irq)
      pending_nxt = 1'b0;
    else if (irq_eff && !in_handler)
      pending_nxt = 1'b1;

    case (state)
      IDLE: begin
        if (take_irq || take_exc) state_nxt = HANDLER;
        else if (irq_eff)         state_nxt = PEND;
      end
      PEND: begin
        if (take_irq || take_exc) state_nxt = HANDLER;
      end
      HANDLER: begin
        if (eret) state_nxt = pending ? PEND : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state boundary: reset discards all context without waiting for clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      pending  <= 1'b0;
      exc_lost <= 1'b0;
      epc      <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      if (exc && in_handler) exc_lost <= 1'b1;
      if (take_exc)      epc <= next_pc(pc_id);
      else if (take_irq) epc <= pc_id;
    end
  end

  assign Interrupt = take_irq && reset;
  assign Exception = take_exc && reset;
  assign busy      = in_handler;

endmodule
